// File: rtl/prbs8_pkg.sv
// Shared definitions for the 8-bit Fibonacci PRBS (x^8+x^6+x^5+x^4+1) generator/checker pair.
package prbs8_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  localparam int PRBS_W = 8;

  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

  function automatic logic prbs8_fb(input logic [PRBS_W-1:0] s);
    return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
  endfunction

endpackage

// File: rtl/prbs8_predict.sv
// Local copy of the PRBS shift register; s[0] is the newest bit, p is the predicted next bit.
module prbs8_predict
  import prbs8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [PRBS_W-1:0] s,
  output logic              p
);

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
    end else if (shift_en) begin
      s <= {s[PRBS_W-2:0], bit_in};
    end
  end

  assign p = prbs8_fb(s);

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 checker: seeds from received data, locks, then flags and counts bit errors.
//
// state  | meaning
// HUNT   | filling the shift register from the line; all-zero window is rejected
// VERIFY | seeded, counting consecutive correct predictions towards lock
// LOCK   | synchronised; register runs on its own prediction, mismatches are errors
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I,
  input  logic             EN,
  input  logic             CLR_COUNT,
  output logic             LOCKED,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_COUNT
);

  localparam logic [7:0] LC = 8'(LOCK_COUNT);
  localparam logic [7:0] UE = 8'(UNLOCK_ERRS);

  state_t              state, state_nxt;
  logic [3:0]          fill, fill_nxt;
  logic [7:0]          match, match_nxt;
  logic [7:0]          miss, miss_nxt;
  logic [PRBS_W-1:0]   s, s_new;
  logic                p, bit_in, mismatch, count_err;

  prbs8_predict u_pred (
    .clk      (CLK),
    .rst      (RESET),
    .shift_en (EN),
    .bit_in   (bit_in),
    .s        (s),
    .p        (p)
  );

  assign s_new     = {s[PRBS_W-2:0], I};
  assign mismatch  = I ^ p;
  // While locked the register free-runs on its prediction so line errors never corrupt it.
  assign bit_in    = (state == LOCK) ? p : I;
  assign count_err = EN && (state == LOCK) && mismatch;

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    match_nxt = match;
    miss_nxt  = miss;
    if (EN) begin
      case (state)
        HUNT: begin
          if (fill >= 4'd7) begin
            fill_nxt = 4'd8;
            if (s_new != '0) begin
              state_nxt = VERIFY;
              match_nxt = 8'd0;
            end
          end else begin
            fill_nxt = fill + 4'd1;
          end
        end
        VERIFY: begin
          if (!mismatch) begin
            match_nxt = match + 8'd1;
            if (match + 8'd1 == LC) begin
              state_nxt = LOCK;
              miss_nxt  = 8'd0;
            end
          end else begin
            state_nxt = HUNT;
            fill_nxt  = 4'd1;
          end
        end
        LOCK: begin
          if (mismatch) begin
            miss_nxt = miss + 8'd1;
            if (miss + 8'd1 == UE) begin
              state_nxt = HUNT;
              fill_nxt  = 4'd0;
              miss_nxt  = 8'd0;
            end
          end else begin
            miss_nxt = 8'd0;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= HUNT;
      fill      <= 4'd0;
      match     <= 8'd0;
      miss      <= 8'd0;
      LOCKED    <= 1'b0;
      ERR       <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      state  <= state_nxt;
      fill   <= fill_nxt;
      match  <= match_nxt;
      miss   <= miss_nxt;
      LOCKED <= (state_nxt == LOCK);
      ERR    <= count_err;
      if (CLR_COUNT) begin
        ERR_COUNT <= count_err ? ERR_W'(1) : '0;
      end else if (count_err && !(&ERR_COUNT)) begin
        ERR_COUNT <= ERR_COUNT + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prbs8_checker.sv
// Randomised bench for prbs8_checker against a bit-history reference model.
module tb_prbs8_checker;

  localparam int LC = 16;
  localparam int UE = 4;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCK = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0, I = 1'b0, EN = 1'b0, CLR_COUNT = 1'b0;
  logic        LOCKED, ERR, LOCKED2, ERR2;
  logic [15:0] ERR_COUNT;
  logic [1:0]  ERR_COUNT2;

  prbs8_checker #(.LOCK_COUNT(LC), .UNLOCK_ERRS(UE), .ERR_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .I(I), .EN(EN), .CLR_COUNT(CLR_COUNT),
    .LOCKED(LOCKED), .ERR(ERR), .ERR_COUNT(ERR_COUNT)
  );

  prbs8_checker #(.LOCK_COUNT(LC), .UNLOCK_ERRS(UE), .ERR_W(2)) dut_w2 (
    .CLK(CLK), .RESET(RESET), .I(I), .EN(EN), .CLR_COUNT(CLR_COUNT),
    .LOCKED(LOCKED2), .ERR(ERR2), .ERR_COUNT(ERR_COUNT2)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit   hist[$];
  int   mode, fill, match, miss;
  bit   m_locked, m_err;
  int   cnt16, cnt2;
  logic [7:0] g = 8'h01;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pred();
    // x[n] = x[n-8] ^ x[n-6] ^ x[n-5] ^ x[n-4]; hist[k] is the bit k+1 shifts ago
    return hist[7] ^ hist[5] ^ hist[4] ^ hist[3];
  endfunction

  task automatic push(input bit b);
    hist.push_front(b);
    void'(hist.pop_back());
  endtask

  task automatic model_reset();
    hist = {};
    for (int k = 0; k < 8; k++) hist.push_back(1'b0);
    mode = M_HUNT; fill = 0; match = 0; miss = 0;
    m_locked = 0; m_err = 0; cnt16 = 0; cnt2 = 0;
  endtask

  task automatic model_step(input bit i_v, input bit en_v, input bit clr_v, input bit rst_v);
    bit p, counted, nz;
    if (rst_v) begin
      model_reset();
      return;
    end
    counted = 0;
    if (en_v) begin
      p = pred();
      if (mode == M_HUNT) begin
        push(i_v);
        fill = (fill < 8) ? fill + 1 : 8;
        nz = 0;
        foreach (hist[k]) nz |= hist[k];
        if (fill == 8 && nz) begin mode = M_VERIFY; match = 0; end
      end else if (mode == M_VERIFY) begin
        push(i_v);
        if (i_v == p) begin
          match++;
          if (match == LC) begin mode = M_LOCK; miss = 0; end
        end else begin
          mode = M_HUNT; fill = 1;
        end
      end else begin
        push(p);
        if (i_v != p) begin
          counted = 1;
          miss++;
          if (miss == UE) begin mode = M_HUNT; fill = 0; miss = 0; end
        end else begin
          miss = 0;
        end
      end
    end
    m_err = counted;
    m_locked = (mode == M_LOCK);
    if (clr_v) begin
      cnt16 = counted; cnt2 = counted;
    end else if (counted) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt2 < 3) cnt2++;
    end
  endtask

  task automatic drive(input logic i_v, input logic en_v, input logic clr_v, input logic rst_v);
    I = i_v; EN = en_v; CLR_COUNT = clr_v; RESET = rst_v;
    @(posedge CLK);
    model_step(i_v, en_v, clr_v, rst_v);
    #1;
    chk("locked", 32'(LOCKED), 32'(m_locked));
    chk("err", 32'(ERR), 32'(m_err));
    chk("count", 32'(ERR_COUNT), 32'(cnt16));
    chk("count_w2", 32'(ERR_COUNT2), 32'(cnt2));
  endtask

  task automatic send(input bit flip, input bit en_v, input bit clr_v);
    logic b;
    if (en_v) begin
      g = {g[6:0], g[7] ^ g[5] ^ g[4] ^ g[3]};
      b = g[0] ^ flip;
    end else begin
      b = 1'($urandom);
    end
    drive(b, en_v, clr_v, 1'b0);
  endtask

  task automatic wait_lock(input int limit, output int n);
    n = 0;
    while (!LOCKED && n < limit) begin
      send(1'b0, 1'b1, 1'b0);
      n++;
    end
  endtask

  int  n;
  bit  inj;

  initial begin
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_locked", 32'(LOCKED), 32'd0);
    chk("rst_count", 32'(ERR_COUNT), 32'd0);

    // clean acquisition from reset
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    g = 8'h01;
    wait_lock(100, n);
    chk("acq_bits", 32'(n), 32'd24);
    for (int k = 0; k < 1000; k++) send(1'b0, 1'b1, 1'b0);
    chk("clean_count", 32'(ERR_COUNT), 32'd0);

    // single error while locked
    send(1'b1, 1'b1, 1'b0);
    chk("single_err", 32'(ERR), 32'd1);
    send(1'b0, 1'b1, 1'b0);
    chk("single_err_pulse", 32'(ERR), 32'd0);
    for (int k = 0; k < 50; k++) send(1'b0, 1'b1, 1'b0);
    chk("single_count", 32'(ERR_COUNT), 32'd1);
    chk("single_locked", 32'(LOCKED), 32'd1);

    // loss of lock after four consecutive errors
    send(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) chk("loss_before", 32'(LOCKED), 32'd1);
      send(1'b1, 1'b1, 1'b0);
    end
    chk("loss_locked", 32'(LOCKED), 32'd0);
    chk("loss_count", 32'(ERR_COUNT), 32'd4);
    chk("loss_count_w2", 32'(ERR_COUNT2), 32'd3);
    wait_lock(100, n);
    chk("relock_bits", 32'(n), 32'd24);

    // illegal all-zero seed, then a fault during VERIFY
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero_locked", 32'(LOCKED), 32'd0);
    inj = 0;
    for (int k = 0; k < 200 && !LOCKED; k++) begin
      bit f;
      f = !inj && mode == M_VERIFY && match == 5;
      send(f, 1'b1, 1'b0);
      if (f) inj = 1;
    end
    chk("vfy_injected", 32'(inj), 32'd1);
    chk("vfy_locked", 32'(LOCKED), 32'd1);
    chk("vfy_count", 32'(ERR_COUNT), 32'd0);

    // random stalls, sparse random errors and clears
    for (int k = 0; k < 600; k++) begin
      bit en_r, fl_r, clr_r;
      en_r  = 1'($urandom_range(0, 1));
      fl_r  = ($urandom_range(0, 49) == 0);
      clr_r = ($urandom_range(0, 39) == 0);
      send(fl_r, en_r, clr_r);
    end
    wait_lock(200, n);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 300; k++) send(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk("stall_count", 32'(ERR_COUNT), 32'd0);
    chk("stall_locked", 32'(LOCKED), 32'd1);

    // five errors saturate the narrow counter; clear coincident with an error
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0);
    end
    chk("sat_w2", 32'(ERR_COUNT2), 32'd3);
    chk("sat_w16", 32'(ERR_COUNT), 32'd5);
    send(1'b1, 1'b1, 1'b1);
    chk("clr_err_count", 32'(ERR_COUNT), 32'd1);
    chk("clr_err_count_w2", 32'(ERR_COUNT2), 32'd1);

    // reset mid-lock with a non-zero count
    send(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      send(1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0);
    end
    chk("pre_rst_count", 32'(ERR_COUNT), 32'd3);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_locked", 32'(LOCKED), 32'd0);
    chk("mid_rst_err", 32'(ERR), 32'd0);
    chk("mid_rst_count", 32'(ERR_COUNT), 32'd0);
    wait_lock(100, n);
    chk("reacq_bits", 32'(n), 32'd24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prbs8_checker.md
# prbs8_checker

Self-synchronising checker for the 8-bit Fibonacci PRBS stream produced by `lfsr81False` (taps 8,6,5,4). It sits directly downstream of the generator, or at the far end of a link carrying its serial bit. It consumes one bit per valid cycle and seeds its own copy of the LFSR from the received data. After seeding it acquires lock, then flags and counts bit errors.

## Interface
Parameters:
- `LOCK_COUNT`, default 16: consecutive correctly-predicted bits required to declare lock (range 1..255).
- `UNLOCK_ERRS`, default 4: consecutive mispredicted bits while locked that drop lock (range 1..255).
- `ERR_W`, default 16: width of the error counter.

Ports:
- `CLK`  in  1  sole clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `I`  in  1  received PRBS bit; the generator's `O[0]` (its newest bit).
- `EN`  in  1  `I` is valid this cycle; when low, no state changes except `CLR_COUNT`.
- `CLR_COUNT`  in  1  synchronous clear of `ERR_COUNT`.
- `LOCKED`  out  1  checker is synchronised to the stream.
- `ERR`  out  1  one-cycle pulse: the previous valid bit mismatched while locked.
- `ERR_COUNT`  out  `ERR_W`  saturating count of locked-state mismatches.

## Operation
Shift register and prediction:
- 8-bit shift register `s`: on each shift, `s <= {s[6:0], b}`, so `s[0]` is the newest bit.
- Predicted next bit `p = s[7]^s[5]^s[4]^s[3]`.
- This matches the generator's SIPO ordering exactly.

State machine (states HUNT, VERIFY, LOCK):
- **HUNT** (reset state)
  - Each valid bit: shift `b=I` and increment `fill` (0..8, saturating).
  - When `fill` would reach 8 and the new `s` is non-zero: go to VERIFY with `match=0`.
  - If the new `s` is all-zero: stay in HUNT with `fill` held at 8; the all-zero state is illegal for this LFSR.
- **VERIFY**
  - Each valid bit: shift `b=I`.
  - If `I==p`: `match++`. When `match` reaches `LOCK_COUNT`, go to LOCK and set `LOCKED`.
  - If `I!=p`: go to HUNT with `fill=1`; the bit just shifted counts as the first fill bit.
  - VERIFY mismatches never assert `ERR` or touch `ERR_COUNT`.
- **LOCK**
  - Each valid bit: shift `b=p` (the prediction, not `I`), so a single bit error cannot corrupt the local LFSR.
  - If `I!=p`: assert `ERR` next cycle; `ERR_COUNT++`, saturating at all-ones; `miss++`.
  - If `I==p`: `miss=0`.
  - When `miss` reaches `UNLOCK_ERRS`: go to HUNT with `fill=0`, deassert `LOCKED`. The errored bit that caused the unlock is still pulsed on `ERR` and counted.

Counter rules:
- `CLR_COUNT` acts whether or not `EN` is high.
- If `CLR_COUNT` and a counted error occur in the same cycle, `ERR_COUNT` becomes 1.

## Timing
- All outputs are registered.
- Reset values: `LOCKED=0`, `ERR=0`, `ERR_COUNT=0`, state HUNT, `s=0`, `fill=match=miss=0`.
- `RESET` overrides everything, including mid-lock and simultaneous `CLR_COUNT`.
- Minimum acquisition time after reset on a clean, continuously valid stream:
  - 8 bits to fill, then `LOCK_COUNT` matched bits.
  - `LOCKED` rises on the edge that samples bit `8+LOCK_COUNT`, and is visible in the following cycle.
- `ERR` is high for exactly the one cycle after the edge that sampled the mismatching bit; it is low in every other cycle, including cycles with `EN` low.
- `EN` low stalls the checker completely: no shift and no counter changes, and gaps of any length are tolerated.
- The checker is back-to-back capable: one bit per cycle and no bubbles.

## Structure
- Shared package `prbs8_pkg`:
  - state enum `{HUNT, VERIFY, LOCK}`;
  - `PRBS_W = 8`;
  - tap index constants 7, 5, 4, 3 (shared with the generator).
- One sub-module, `prbs8_predict`: the 8-bit shift register plus combinational `p`, with inputs `shift_en` and `bit_in`.
- The FSM, counters and outputs live in `prbs8_checker`.

## Test plan
- **Clean lock:** drive `lfsr81False` (reset state 8'h01) `O[0]` into `I`, with `EN=1` from reset → `LOCKED` rises after 24 sampled bits; `ERR` stays 0 and `ERR_COUNT==0` for 1000 cycles.
- **Single error while locked:** invert `I` for one bit → `ERR` high for exactly one cycle, `ERR_COUNT==1`, `LOCKED` stays 1, and no further errors follow (predictive feed).
- **Loss of lock:** invert 4 consecutive bits → `ERR_COUNT==4`, `LOCKED` falls after the 4th; relock follows 24 clean bits later.
- **Illegal seed and VERIFY fault:**
  - Feed 12 zeros → checker stays in HUNT, `LOCKED=0`.
  - Then feed a valid stream with one error inside VERIFY → no `ERR` pulse, `ERR_COUNT` unchanged, lock delayed and then achieved.
- **Stall and counter:**
  - Toggle `EN` randomly 50% on a locked stream → no errors.
  - `ERR_W=2` with 5 errors → `ERR_COUNT` saturates at 3.
  - `CLR_COUNT` concurrent with an error → `ERR_COUNT==1`.
- **Reset mid-lock:** assert `RESET` for one cycle while locked with `ERR_COUNT=3` → all outputs 0 in the next cycle, and reacquisition takes 24 bits.
